// File: rtl/period_meter.sv
// period_meter: counts clk_in cycles spanning NPeriods rising-edge periods of sig_in
// and reports the summed and averaged period, with timeout and overflow flags.
module period_meter #(
    parameter int CntWidth  = 16,
    parameter int NPeriods  = 4,
    parameter int MaxCycles = 4096
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                sig_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CntWidth-1:0] period_sum,
    output logic [CntWidth-1:0] period_avg,
    output logic                timeout,
    output logic                overflow
);
    localparam int Shift = $clog2(NPeriods);
    localparam int TW    = $clog2(MaxCycles);

    localparam logic [CntWidth-1:0] CntMax     = '1;
    localparam logic [TW-1:0]       TLimit     = TW'(MaxCycles - 1);
    localparam logic [8:0]          EdgeTarget = 9'(NPeriods);

    if (NPeriods < 1 || NPeriods > 256 || (NPeriods & (NPeriods - 1)) != 0) begin : g_bad_nperiods
        $error("period_meter: NPeriods must be a power of two in 1..256");
    end
    if (MaxCycles < 2) begin : g_bad_maxcycles
        $error("period_meter: MaxCycles must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sig_q;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [8:0]          edges_q, edges_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CntWidth-1:0] sum_q, sum_d;
    logic [CntWidth-1:0] avg_q, avg_d;
    logic                timeout_q, timeout_d;
    logic                overflow_q, overflow_d;
    logic                rise_s, sat_s, finish_ok_s, finish_to_s;

    // Next-state and result computation for the measurement FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        edges_d     = edges_q;
        tcnt_d      = tcnt_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        sum_d       = sum_q;
        avg_d       = avg_q;
        timeout_d   = timeout_q;
        overflow_d  = overflow_q;
        finish_ok_s = 1'b0;
        finish_to_s = 1'b0;
        rise_s      = sig_in & ~sig_q;
        sat_s       = (cnt_q == CntMax);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                    edges_d = 9'd0;
                    tcnt_d  = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM: begin
                if (rise_s) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    edges_d = 9'd0;
                    tcnt_d  = '0;
                end else if (tcnt_q == TLimit) begin
                    finish_to_s = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            MEASURE: begin
                cnt_d = sat_s ? cnt_q : cnt_q + 1'b1;
                ovf_d = ovf_q | sat_s;
                // A rise on the timeout threshold cycle still counts as a normal edge.
                if (rise_s) begin
                    edges_d = edges_q + 9'd1;
                    tcnt_d  = '0;
                    if (edges_d == EdgeTarget) begin
                        finish_ok_s = 1'b1;
                    end else begin
                        finish_ok_s = 1'b0;
                    end
                end else if (tcnt_q == TLimit) begin
                    finish_to_s = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // cnt_d already holds min(cnt+1, max), which is exactly the span to report.
        if (finish_ok_s) begin
            sum_d      = cnt_d;
            avg_d      = cnt_d >> Shift;
            overflow_d = ovf_d;
            timeout_d  = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
        end else if (finish_to_s) begin
            sum_d      = '0;
            avg_d      = '0;
            overflow_d = ovf_d;
            timeout_d  = 1'b1;
            done_d     = 1'b1;
            state_d    = IDLE;
        end else begin
            done_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    // State, edge history and result registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sig_q      <= 1'b0;
            cnt_q      <= '0;
            edges_q    <= 9'd0;
            tcnt_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_q      <= '0;
            avg_q      <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_in;
            cnt_q      <= cnt_d;
            edges_q    <= edges_d;
            tcnt_q     <= tcnt_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sum_q      <= sum_d;
            avg_q      <= avg_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign period_sum = sum_q;
    assign period_avg = avg_q;
    assign timeout    = timeout_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: randomized square waves on sig_in checked
// against an arithmetic model of the expected sum/average/flags.
module tb_period_meter;
    localparam int N  = 4;
    localparam int MC = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sig_in = 1'b0;
    logic        start = 1'b0;
    logic        start8 = 1'b0;
    logic        busy, done, timeout, overflow;
    logic [15:0] period_sum, period_avg;
    logic        busy8, done8, timeout8, overflow8;
    logic [7:0]  sum8, avg8;

    int n_checks = 0;
    int n_fail   = 0;

    int wave_period = 10;
    int wave_high   = 5;
    int phase       = 0;
    bit wave_en     = 1'b0;
    bit hold_level  = 1'b0;

    period_meter #(.CntWidth(16), .NPeriods(N), .MaxCycles(MC)) u_dut (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
        .busy(busy), .done(done), .period_sum(period_sum), .period_avg(period_avg),
        .timeout(timeout), .overflow(overflow)
    );

    period_meter #(.CntWidth(8), .NPeriods(N), .MaxCycles(MC)) u_dut8 (
        .clk_in(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start8),
        .busy(busy8), .done(done8), .period_sum(sum8), .period_avg(avg8),
        .timeout(timeout8), .overflow(overflow8)
    );

    always #5 clk = ~clk;

    // Wave generator: updates sig_in shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (wave_en) begin
                sig_in = (phase < wave_high);
                phase  = (phase + 1) % wave_period;
            end else begin
                sig_in = hold_level;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a full measurement spans N periods, clipped to the counter range.
    function automatic void exp_meas(input int p, input int cw, output int sum, output int avg,
                                     output bit ovf);
        int full, maxv;
        full = N * p;
        maxv = (1 << cw) - 1;
        ovf  = (full > maxv);
        sum  = ovf ? maxv : full;
        avg  = sum / N;
    endfunction

    task automatic set_wave(input int p, input int h, input int ph);
        wave_period = p;
        wave_high   = h;
        phase       = ph;
        wave_en     = 1'b1;
    endtask

    task automatic start_pulse(input bit sel8);
        @(negedge clk);
        if (sel8) start8 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit sel8, input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < limit) begin
            @(negedge clk);
            cycles++;
            seen = sel8 ? done8 : done;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, timeout, overflow, period_sum, period_avg} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b to=%b ov=%b sum=%0d avg=%0d, want all 0",
                     busy, done, timeout, overflow, period_sum, period_avg);
        end
        n_checks++;
        if ({busy8, done8, timeout8, overflow8, sum8, avg8} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs8: got busy=%b done=%b to=%b ov=%b sum=%0d avg=%0d, want all 0",
                     busy8, done8, timeout8, overflow8, sum8, avg8);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square();
        int p, h, cyc, es, ea;
        bit seen, eo;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                p = 10; h = 5;
            end else begin
                p = $urandom_range(60, 3);
                h = $urandom_range(p - 1, 1);
            end
            set_wave(p, h, $urandom_range(p - 1, 0));
            repeat (3) @(negedge clk);
            exp_meas(p, 16, es, ea, eo);
            start_pulse(1'b0);
            wait_done(1'b0, 6000, cyc, seen);
            n_checks++;
            if (!seen) begin
                n_fail++;
                $display("FAIL square_done p=%0d: no done after %0d cycles", p, cyc);
            end
            n_checks++;
            if (period_sum !== es[15:0] || period_avg !== ea[15:0]) begin
                n_fail++;
                $display("FAIL square_result p=%0d: got sum=%0d avg=%0d, want sum=%0d avg=%0d",
                         p, period_sum, period_avg, es, ea);
            end
            n_checks++;
            if ({busy, timeout, overflow} !== {1'b0, 1'b0, eo}) begin
                n_fail++;
                $display("FAIL square_flags p=%0d: got busy=%b to=%b ov=%b, want 0 0 %b",
                         p, busy, timeout, overflow, eo);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL square_done_width p=%0d: done=%b one cycle later, want 0", p, done);
            end
        end
    endtask

    task automatic test_freq_gen();
        int p, cyc, es, ea;
        bit seen, eo;
        for (int sel = 0; sel < 2; sel++) begin
            p = (1 << 9) / (sel + 1);
            set_wave(p, p / 2, 0);
            repeat (3) @(negedge clk);
            exp_meas(p, 16, es, ea, eo);
            start_pulse(1'b0);
            wait_done(1'b0, 6000, cyc, seen);
            n_checks++;
            if (!seen || period_sum !== es[15:0] || period_avg !== ea[15:0] || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL freq_gen sel=%0d: got done=%b sum=%0d avg=%0d to=%b, want 1 %0d %0d 0",
                         sel, seen, period_sum, period_avg, timeout, es, ea);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        wave_en    = 1'b0;
        hold_level = 1'b0;
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        wait_done(1'b0, MC + 100, cyc, seen);
        n_checks++;
        if (!seen || cyc != MC) begin
            n_fail++;
            $display("FAIL timeout_latency: got done=%b after %0d cycles, want done after %0d", seen, cyc, MC);
        end
        n_checks++;
        if ({timeout, overflow, busy} !== 3'b100 || period_sum !== 16'd0 || period_avg !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_result: got to=%b ov=%b busy=%b sum=%0d avg=%0d, want 1 0 0 0 0",
                     timeout, overflow, busy, period_sum, period_avg);
        end
        set_wave(10, 5, 0);
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        wait_done(1'b0, 6000, cyc, seen);
        n_checks++;
        if (!seen || timeout !== 1'b0 || period_sum !== 16'd40) begin
            n_fail++;
            $display("FAIL timeout_recover: got done=%b to=%b sum=%0d, want 1 0 40", seen, timeout, period_sum);
        end
    endtask

    task automatic test_overflow();
        int p, cyc, es, ea;
        bit seen, eo;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? 100 : $urandom_range(60, 10);
            set_wave(p, p / 2, 0);
            repeat (3) @(negedge clk);
            exp_meas(p, 8, es, ea, eo);
            start_pulse(1'b1);
            wait_done(1'b1, 6000, cyc, seen);
            n_checks++;
            if (!seen || sum8 !== es[7:0] || avg8 !== ea[7:0] || overflow8 !== eo || timeout8 !== 1'b0) begin
                n_fail++;
                $display("FAIL overflow p=%0d: got done=%b sum=%0d avg=%0d ov=%b to=%b, want 1 %0d %0d %b 0",
                         p, seen, sum8, avg8, overflow8, timeout8, es, ea, eo);
            end
        end
    endtask

    task automatic test_start_busy();
        int cyc0, cyc;
        bit seen;
        set_wave(10, 5, 0);
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        wait_done(1'b0, 6000, cyc0, seen);
        set_wave(10, 5, 0);
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1; else start = ((cyc % 7) == 3);
        end
        n_checks++;
        if (!seen || cyc != cyc0 || period_sum !== 16'd40 || period_avg !== 16'd10) begin
            n_fail++;
            $display("FAIL start_busy: got done=%b at %0d sum=%0d avg=%0d, want done at %0d sum=40 avg=10",
                     seen, cyc, period_sum, period_avg, cyc0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_done: busy=%b the cycle after start in done cycle, want 1", busy);
        end
        wait_done(1'b0, 6000, cyc, seen);
        n_checks++;
        if (!seen || period_sum !== 16'd40) begin
            n_fail++;
            $display("FAIL start_in_done_result: got done=%b sum=%0d, want 1 40", seen, period_sum);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        set_wave(10, 5, 0);
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({busy, done, timeout, overflow, period_sum, period_avg} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b to=%b ov=%b sum=%0d avg=%0d, want all 0",
                     busy, done, timeout, overflow, period_sum, period_avg);
        end
        wait_done(1'b0, 80, cyc, seen);
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nodone: got done=%b busy=%b after reset, want 0 0", seen, busy);
        end
        start_pulse(1'b0);
        wait_done(1'b0, 6000, cyc, seen);
        n_checks++;
        if (!seen || period_sum !== 16'd40 || period_avg !== 16'd10) begin
            n_fail++;
            $display("FAIL reset_mid_recover: got done=%b sum=%0d avg=%0d, want 1 40 10",
                     seen, period_sum, period_avg);
        end
    endtask

    task automatic test_level_high();
        int cyc, es, ea;
        bit seen, eo;
        wave_en    = 1'b0;
        hold_level = 1'b1;
        repeat (3) @(negedge clk);
        start_pulse(1'b0);
        wait_done(1'b0, 20, cyc, seen);
        n_checks++;
        if (seen || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL level_high_wait: got done=%b busy=%b while held high, want 0 1", seen, busy);
        end
        set_wave(12, 6, 6);
        exp_meas(12, 16, es, ea, eo);
        wait_done(1'b0, 6000, cyc, seen);
        n_checks++;
        if (!seen || period_sum !== es[15:0] || period_avg !== ea[15:0] || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL level_high_result: got done=%b sum=%0d avg=%0d to=%b, want 1 %0d %0d 0",
                     seen, period_sum, period_avg, timeout, es, ea);
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_freq_gen();
        test_timeout();
        test_overflow();
        test_start_busy();
        test_reset_mid();
        test_level_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measurement stage directly downstream of freq_gen. It consumes freq_gen's clk_out, which is synchronous to clk_in, on sig_in.
- On a start pulse it counts clk_in cycles across NPeriods full periods of sig_in. It then reports the summed and averaged period in clk_in cycles, with timeout and overflow flags.
- Used for on-chip self-check of the generator, for example to sweep freq_sel and compare the result against 2^(DataWidth+1)/(freq_sel+1).

Parameters:
CntWidth, 16, width of cycle counter and period_sum/period_avg.
NPeriods, 4, periods of sig_in accumulated per measurement. Must be a power of two, 1..256; any other value is an elaboration error.
MaxCycles, 4096, clk_in cycles allowed between consecutive rising edges (or from start to the first edge) before timeout. Must be ≥2.

Ports:
clk_in  in  1  system clock; all logic on its rising edge
rst_n  in  1  reset, synchronous, active-low
sig_in  in  1  measured signal (freq_gen clk_out), synchronous to clk_in
start  in  1  one-cycle request to begin a measurement
busy  out  1  measurement in progress
done  out  1  one-cycle pulse: results updated
period_sum  out  CntWidth  clk_in cycles spanning NPeriods periods
period_avg  out  CntWidth  period_sum >> log2(NPeriods)
timeout  out  1  last measurement aborted by timeout
overflow  out  1  last measurement saturated the counter

Behaviour:
- Interface: one clock (clk_in); reset is synchronous and active-low (rst_n).
- Reset: when rst_n=0 at a clk_in edge, the state goes to IDLE. busy, done, period_sum, period_avg, timeout and overflow all go to 0. The sig_in history register (sig_q) goes to 0.
- Reset mid-measurement aborts the measurement, with no done pulse.
- Edge detect: sig_q <= sig_in every cycle in all states. A rise is detected in a cycle where sig_in=1 and sig_q=0.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: busy=0. When start=1, go to ARM and clear cnt, edges, tcnt and the sticky ovf. start is ignored in ARM and MEASURE.
  - ARM: busy=1. On a rise, go to MEASURE with cnt:=0, edges:=0, tcnt:=0. The first ARM cycle already samples rises.
  - MEASURE: busy=1. Every cycle cnt:=cnt+1, saturating at 2^CntWidth-1; saturation sets ovf.
    - On a rise: edges:=edges+1 and tcnt:=0.
    - When that rise makes edges=NPeriods: register period_sum:=min(cnt+1, 2^CntWidth-1), period_avg:=period_sum>>log2(NPeriods), overflow:=ovf, timeout:=0. Assert done for the next cycle and go to IDLE.
- Sum arithmetic: for a period of P cycles, period_sum = NPeriods*P.
- Timeout: tcnt counts cycles in ARM/MEASURE since entry or since the last rise. If tcnt reaches MaxCycles-1 with no rise:
  - register timeout:=1, period_sum:=0, period_avg:=0, overflow:=ovf;
  - pulse done and go to IDLE.
  - A rise in the same cycle as the timeout threshold wins: it is counted, and there is no timeout.
- done / busy timing: done is registered and high exactly one cycle. busy falls in the same cycle done rises. Since the state is IDLE during done, a start in the done cycle is accepted and busy rises the next cycle.
- Result holding: results and flags hold until the next done. Starting a new measurement does not clear them.
- Latency: done rises 1 cycle after the clk_in edge that samples the NPeriods-th rise after the arming rise.
- Level-high at arm: if sig_in is already high at start, the first rise after it goes low is the arming edge.

Test Plan:
- Square wave, period 10 cycles (5 high/5 low), NPeriods=4, start pulse → done once, period_sum=40, period_avg=10, timeout=0, overflow=0, busy low in the done cycle.
- Drive sig_in from freq_gen (DataWidth=8, freq_sel=0), NPeriods=4 → period_sum=2048, period_avg=512. Repeat with freq_sel=1: period_sum=1024, period_avg=256.
- sig_in held 0, MaxCycles=4096, start → done exactly 4096 cycles after entering ARM, timeout=1, period_sum=0. Then a 10-cycle wave with a new start → timeout=0, period_sum=40.
- CntWidth=8, period 100, NPeriods=4 → period_sum=255, period_avg=63, overflow=1.
- Start asserted while busy → ignored: a single done, with the same results as the unperturbed run. Start asserted in the done cycle → new measurement begins, busy=1 next cycle.
- rst_n=0 for one cycle mid-MEASURE → next cycle busy=0, all outputs 0, no done pulse. A subsequent start measures correctly (period_sum=40 for a 10-cycle wave).
